// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
// Shares the single synchronous write port of the picoMIPS register file
// between CPU writeback (requester 0) and the debug/loader port (requester 1).
// Requester 0 has fixed priority. An aging counter stops requester 1 from
// starving. Requester 1 may also take an exclusive, time-bounded lock.
//
// Handshake: a requester raises req and holds req/addr/data stable until it
// sees its ack high. The ack is combinational in the same cycle as the
// register-file write enable, and the write commits on the rising edge that
// ends that cycle. The requester may present a new write in the next cycle.
module regfile_write_arbiter #(
    parameter int N        = 8,
    parameter int R_SIZE   = 2,
    parameter int MAX_WAIT = 3,
    parameter int LOCK_MAX = 8
) (
    input  logic              clk,
    input  logic              nReset,
    input  logic              req0In,
    input  logic [R_SIZE-1:0] addr0In,
    input  logic [N-1:0]      data0In,
    output logic              ack0Out,
    input  logic              req1In,
    input  logic [R_SIZE-1:0] addr1In,
    input  logic [N-1:0]      data1In,
    input  logic              lock1In,
    output logic              ack1Out,
    output logic              wrEnOut,
    output logic [R_SIZE-1:0] wrAddrOut,
    output logic [N-1:0]      wrDataOut,
    output logic              busyOut
);

    localparam int WW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam int LW = $clog2(LOCK_MAX + 1);
    localparam logic [WW-1:0] WAIT_LIM  = WW'(MAX_WAIT);
    localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_MAX - 1);

    // HOLDOFF arbitrates exactly like ARB but cannot re-enter LOCKED until
    // lock1In has been seen low, which stops a lock holder from chaining locks.
    typedef enum logic [1:0] {
        ST_ARB     = 2'd0,
        ST_LOCKED  = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;

    state_t          r_state;
    logic [WW-1:0]   r_wait_cnt;
    logic [LW-1:0]   r_lock_cnt;
    logic            w_grant0;
    logic            w_grant1;
    logic            w_contested;

    assign w_contested = req0In && req1In;

    // Grant decision from registered state and the current requests.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (nReset) begin
            if (r_state == ST_LOCKED) begin
                w_grant1 = req1In;
            end else if (w_contested) begin
                if (r_wait_cnt < WAIT_LIM) begin
                    w_grant0 = 1'b1;
                end else begin
                    w_grant1 = 1'b1;
                end
            end else begin
                w_grant0 = req0In;
                w_grant1 = req1In;
            end
        end
    end

    // Drive the acks and the write port. Address and data are zero when
    // no write is issued.
    always_comb begin
        ack0Out   = w_grant0;
        ack1Out   = w_grant1;
        wrEnOut   = w_grant0 | w_grant1;
        wrAddrOut = '0;
        wrDataOut = '0;
        if (w_grant0) begin
            wrAddrOut = addr0In;
            wrDataOut = data0In;
        end else if (w_grant1) begin
            wrAddrOut = addr1In;
            wrDataOut = data1In;
        end
        busyOut = nReset && (r_state == ST_LOCKED);
    end

    // State, aging counter and lock timer.
    always_ff @(posedge clk) begin
        if (!nReset) begin
            r_state    <= ST_ARB;
            r_wait_cnt <= '0;
            r_lock_cnt <= '0;
        end else begin
            case (r_state)
                ST_LOCKED: begin
                    r_wait_cnt <= '0;
                    r_lock_cnt <= r_lock_cnt + LW'(1);
                    if (!lock1In) begin
                        r_state <= ST_ARB;
                    end else if (r_lock_cnt == LOCK_LAST) begin
                        r_state <= ST_HOLDOFF;
                    end
                end
                default: begin
                    // Count one more denial only when requester 1 lost a contest.
                    if (w_contested && !w_grant1) begin
                        r_wait_cnt <= r_wait_cnt + WW'(1);
                    end else begin
                        r_wait_cnt <= '0;
                    end
                    if (r_state == ST_HOLDOFF) begin
                        if (!lock1In) begin
                            r_state <= ST_ARB;
                        end
                    end else if (w_grant1 && lock1In) begin
                        r_state    <= ST_LOCKED;
                        r_lock_cnt <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter
// Directed bench for regfile_write_arbiter. A behavioural model of the
// arbitration rules predicts every output on every cycle, and hand-computed
// literal expectations pin the model at the key points of each scenario.
module tb_regfile_write_arbiter;

    localparam int N        = 8;
    localparam int R_SIZE   = 2;
    localparam int MAX_WAIT = 3;
    localparam int LOCK_MAX = 8;

    logic              clk = 1'b0;
    logic              nReset = 1'b0;
    logic              req0In = 1'b0;
    logic [R_SIZE-1:0] addr0In = '0;
    logic [N-1:0]      data0In = '0;
    logic              ack0Out;
    logic              req1In = 1'b0;
    logic [R_SIZE-1:0] addr1In = '0;
    logic [N-1:0]      data1In = '0;
    logic              lock1In = 1'b0;
    logic              ack1Out;
    logic              wrEnOut;
    logic [R_SIZE-1:0] wrAddrOut;
    logic [N-1:0]      wrDataOut;
    logic              busyOut;

    int checks = 0;
    int errors = 0;

    // Register file image built from the DUT's write port.
    logic [N-1:0] rf [0:(1<<R_SIZE)-1];

    // Behavioural model: lock / holdoff modes, denial count, cycles in lock.
    bit m_locked;
    bit m_holdoff;
    int m_denials;
    int m_lock_age;

    // Expected grant sequence for the contested run: {ack1, ack0}.
    logic [1:0] exp_q[$];

    // Clock generation.
    always #5 clk = ~clk;

    regfile_write_arbiter #(
        .N(N), .R_SIZE(R_SIZE), .MAX_WAIT(MAX_WAIT), .LOCK_MAX(LOCK_MAX)
    ) dut (
        .clk(clk), .nReset(nReset),
        .req0In(req0In), .addr0In(addr0In), .data0In(data0In), .ack0Out(ack0Out),
        .req1In(req1In), .addr1In(addr1In), .data1In(data1In), .lock1In(lock1In),
        .ack1Out(ack1Out), .wrEnOut(wrEnOut), .wrAddrOut(wrAddrOut),
        .wrDataOut(wrDataOut), .busyOut(busyOut)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    // Register file image updated on each committed write.
    always @(posedge clk) begin
        if (wrEnOut) rf[wrAddrOut] <= wrDataOut;
    end

    // Compare process: predict outputs from the model, check, then advance
    // the model over the coming edge (inputs are stable until then).
    always @(negedge clk) begin
        bit g0, g1, busy;
        logic [R_SIZE-1:0] ea;
        logic [N-1:0] ed;
        g0 = 1'b0;
        g1 = 1'b0;
        busy = 1'b0;
        if (!nReset) begin
            m_locked   = 1'b0;
            m_holdoff  = 1'b0;
            m_denials  = 0;
            m_lock_age = 0;
        end else if (m_locked) begin
            busy = 1'b1;
            g1 = req1In;
            m_lock_age++;
            if (!lock1In) begin
                m_locked = 1'b0;
            end else if (m_lock_age == LOCK_MAX) begin
                m_locked  = 1'b0;
                m_holdoff = 1'b1;
            end
        end else begin
            if (req0In && req1In) begin
                if (m_denials >= MAX_WAIT) g1 = 1'b1;
                else g0 = 1'b1;
            end else begin
                g0 = req0In;
                g1 = req1In;
            end
            if (req0In && req1In && g0) m_denials++;
            else m_denials = 0;
            if (m_holdoff) begin
                if (!lock1In) m_holdoff = 1'b0;
            end else if (g1 && lock1In) begin
                m_locked   = 1'b1;
                m_lock_age = 0;
            end
        end
        ea = g0 ? addr0In : (g1 ? addr1In : '0);
        ed = g0 ? data0In : (g1 ? data1In : '0);
        check("m_ack0", 32'(ack0Out), 32'(g0));
        check("m_ack1", 32'(ack1Out), 32'(g1));
        check("m_wren", 32'(wrEnOut), 32'(g0 | g1));
        check("m_addr", 32'(wrAddrOut), 32'(ea));
        check("m_data", 32'(wrDataOut), 32'(ed));
        check("m_busy", 32'(busyOut), 32'(busy));
    end

    // Time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout reached at %0t", $time);
        $fatal(1, "timeout");
    end

    // Directed stimulus with literal expectations.
    initial begin
        int busy_cycles;
        for (int i = 0; i < (1 << R_SIZE); i++) rf[i] = '0;

        // Reset with requests active: every output must be 0.
        nReset = 1'b0; req0In = 1'b1; addr0In = 2'd1; data0In = 8'h55;
        req1In = 1'b1; addr1In = 2'd3; data1In = 8'h66; lock1In = 1'b1;
        settle();
        check("rst_ack0", 32'(ack0Out), 0);
        check("rst_ack1", 32'(ack1Out), 0);
        check("rst_wren", 32'(wrEnOut), 0);
        check("rst_busy", 32'(busyOut), 0);
        tick();
        tick();

        // Idle cycle, with address/data wiggling but no request.
        nReset = 1'b1; req0In = 1'b0; req1In = 1'b0; lock1In = 1'b0;
        addr1In = 2'd3; data1In = 8'hAA;
        settle();
        check("idle_wren", 32'(wrEnOut), 0);
        tick();

        // Single requester-0 write.
        req0In = 1'b1; addr0In = 2'd2; data0In = 8'hE9;
        settle();
        check("w0_ack0", 32'(ack0Out), 1);
        check("w0_wren", 32'(wrEnOut), 1);
        check("w0_addr", 32'(wrAddrOut), 2);
        check("w0_data", 32'(wrDataOut), 32'hE9);
        tick();
        req0In = 1'b0;
        settle();
        check("rf2", 32'(rf[2]), 32'hE9);
        tick();

        // Continuous contention: 0,0,0,1,0,0,0,1.
        exp_q = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b10};
        req0In = 1'b1; addr0In = 2'd1; data0In = 8'h11;
        req1In = 1'b1; addr1In = 2'd3; data1In = 8'h33;
        for (int i = 0; i < 8; i++) begin
            settle();
            check("grant_seq", 32'({ack1Out, ack0Out}), 32'(exp_q.pop_front()));
            tick();
        end
        req0In = 1'b0; req1In = 1'b0;
        tick();

        // Lock with requester 0 stalled, then release.
        req1In = 1'b1; lock1In = 1'b1; addr1In = 2'd0; data1In = 8'hC3;
        settle();
        check("lk_grant", 32'(ack1Out), 1);
        check("lk_busy0", 32'(busyOut), 0);
        tick();
        req0In = 1'b1; addr0In = 2'd1; data0In = 8'h5A;
        for (int i = 0; i < 4; i++) begin
            settle();
            check("lk_busy", 32'(busyOut), 1);
            check("lk_ack0", 32'(ack0Out), 0);
            check("lk_ack1", 32'(ack1Out), 1);
            tick();
        end
        lock1In = 1'b0;
        settle();
        check("lk_drop_busy", 32'(busyOut), 1);
        check("lk_drop_ack1", 32'(ack1Out), 1);
        tick();
        req1In = 1'b0;
        settle();
        check("unlock_busy", 32'(busyOut), 0);
        check("unlock_ack0", 32'(ack0Out), 1);
        tick();
        req0In = 1'b0;
        tick();

        // Lock timeout: 12 cycles of lock1In high.
        busy_cycles = 0;
        req1In = 1'b1; lock1In = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            if (c >= 10) req0In = 1'b1;
            settle();
            if (busyOut) busy_cycles++;
            if (c >= 10) check("holdoff_ack0", 32'(ack0Out), 1);
            tick();
        end
        check("busy_cycles", 32'(busy_cycles), 8);
        req0In = 1'b0;
        settle();
        check("holdoff_ack1", 32'(ack1Out), 1);
        tick();
        settle();
        check("no_relock", 32'(busyOut), 0);
        tick();
        lock1In = 1'b0;
        settle();
        check("holdoff_exit", 32'(busyOut), 0);
        tick();
        lock1In = 1'b1;
        settle();
        check("relock_grant", 32'(ack1Out), 1);
        tick();
        settle();
        check("relock_busy", 32'(busyOut), 1);
        tick();

        // Reset in the middle of a lock.
        req0In = 1'b1; nReset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            settle();
            check("mrst_ack0", 32'(ack0Out), 0);
            check("mrst_ack1", 32'(ack1Out), 0);
            check("mrst_wren", 32'(wrEnOut), 0);
            check("mrst_addr", 32'(wrAddrOut), 0);
            check("mrst_data", 32'(wrDataOut), 0);
            check("mrst_busy", 32'(busyOut), 0);
            tick();
        end
        nReset = 1'b1;
        settle();
        check("post_rst_ack0", 32'(ack0Out), 1);
        check("post_rst_ack1", 32'(ack1Out), 0);
        check("post_rst_busy", 32'(busyOut), 0);
        tick();
        req0In = 1'b0; req1In = 1'b0; lock1In = 1'b0;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
